// File: rtl/interrupt_controller_if.sv
// Bus, interrupt-source and CPU handshake signals of the interrupt controller.
interface interrupt_controller_if;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;
  logic [7:0] irq_in;
  logic [7:0] irq_clr;
  logic       int_req;
  logic [2:0] int_vector;
  logic       int_ack;
  logic       int_done;

  modport slave (
    input  din, address, w_en, r_en, irq_in, int_ack, int_done,
    output dout, irq_clr, int_req, int_vector
  );

  modport master (
    output din, address, w_en, r_en, irq_in, int_ack, int_done,
    input  dout, irq_clr, int_req, int_vector
  );
endinterface

// File: rtl/interrupt_controller.sv
// Fixed-priority 8-source interrupt controller; INTC_EDGE_LATCH_EN selects edge-latched pending.
// Request 1 cycle after an active source, reads 1 cycle; no backpressure, the CPU paces it via ack/done.
module interrupt_controller #(
  parameter logic [7:0] INTC_ADDRESS = 8'h00
) (
  input logic                   clk,
  input logic                   rst,
  interrupt_controller_if.slave bus
);
  localparam logic [7:0] ADDR_ENABLE  = INTC_ADDRESS;
  localparam logic [7:0] ADDR_PENDING = INTC_ADDRESS + 8'd1;
  localparam logic [7:0] ADDR_CONTROL = INTC_ADDRESS + 8'd2;
  localparam logic [7:0] ADDR_VECTOR  = INTC_ADDRESS + 8'd3;

  typedef enum logic [1:0] {IDLE, PEND, SERVICE} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_enable, r_control, r_dout, w_rd_dat;
  logic [7:0] r_irq_clr, w_irq_clr_nxt;
  logic       r_int_req, w_int_req_nxt;
  logic [2:0] r_int_vector, w_int_vector_nxt, w_winner;
  logic [7:0] w_pending, w_active;
  logic       w_wr_enable, w_wr_control, w_in_service;

  assign w_wr_enable  = bus.w_en && (bus.address == ADDR_ENABLE);
  assign w_wr_control = bus.w_en && (bus.address == ADDR_CONTROL);
  assign w_in_service = (r_state == SERVICE);

`ifdef INTC_EDGE_LATCH_EN
  logic [7:0] r_pending, r_irq_old;
  logic [7:0] w_w1c;

  assign w_w1c = (bus.w_en && (bus.address == ADDR_PENDING)) ? bus.din : 8'h00;

  // A new rising edge wins over a clear landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 8'h00;
      r_irq_old <= 8'h00;
    end else begin
      r_irq_old <= bus.irq_in;
      r_pending <= (r_pending & ~r_irq_clr & ~w_w1c) | (bus.irq_in & ~r_irq_old);
    end
  end

  assign w_pending = r_pending;
`else
  assign w_pending = bus.irq_in;
`endif

  assign w_active = w_pending & r_enable;

  always_comb begin
    w_winner = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_active[i]) w_winner = 3'(i);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_int_req_nxt    = r_int_req;
    w_int_vector_nxt = r_int_vector;
    w_irq_clr_nxt    = 8'h00;
    case (r_state)
      IDLE: begin
        w_int_req_nxt = 1'b0;
        if (r_control[0] && (w_active != 8'h00)) begin
          w_state_nxt      = PEND;
          w_int_req_nxt    = 1'b1;
          w_int_vector_nxt = w_winner;
        end
      end
      PEND: begin
        // The vector registered during the ack cycle is the one serviced.
        if (bus.int_ack) begin
          w_state_nxt   = SERVICE;
          w_int_req_nxt = 1'b0;
          w_irq_clr_nxt = 8'h01 << r_int_vector;
        end else if ((w_active == 8'h00) || (w_wr_control && !bus.din[0])) begin
          w_state_nxt   = IDLE;
          w_int_req_nxt = 1'b0;
        end else begin
          w_int_req_nxt    = 1'b1;
          w_int_vector_nxt = w_winner;
        end
      end
      SERVICE: begin
        w_int_req_nxt = 1'b0;
        if (bus.int_done) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt   = IDLE;
        w_int_req_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_rd_dat = 8'h00;
    if (bus.address == ADDR_ENABLE)       w_rd_dat = r_enable;
    else if (bus.address == ADDR_PENDING) w_rd_dat = w_pending;
    else if (bus.address == ADDR_CONTROL) w_rd_dat = r_control;
    else if (bus.address == ADDR_VECTOR)  w_rd_dat = {w_in_service, 4'b0000, r_int_vector};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_int_req    <= 1'b0;
      r_int_vector <= 3'd0;
      r_irq_clr    <= 8'h00;
      r_enable     <= 8'h00;
      r_control    <= 8'h00;
      r_dout       <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_int_req    <= w_int_req_nxt;
      r_int_vector <= w_int_vector_nxt;
      r_irq_clr    <= w_irq_clr_nxt;
      if (w_wr_enable)  r_enable  <= bus.din;
      if (w_wr_control) r_control <= bus.din;
      if (bus.r_en)     r_dout    <= w_rd_dat;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.irq_clr    = r_irq_clr;
  assign bus.int_req    = r_int_req;
  assign bus.int_vector = r_int_vector;
endmodule
